// File: rtl/rf_ldst_sched.sv
// Load/store command scheduler: round-robin arbitration across requesters, then splits
// each command into engine transfers of at most MAX_CHUNK lines with registered engine outputs.
module rf_ldst_sched #(
    parameter  int NUM_REQ    = 2,
    parameter  int RF_ADDR_W  = 9,
    parameter  int LINE_BYTES = 176,
    parameter  int MAX_CHUNK  = 16,
    localparam int OWNER_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_store,
    input  logic [NUM_REQ*32-1:0]         req_sdram_addr,
    input  logic [NUM_REQ*RF_ADDR_W-1:0]  req_rf_addr,
    input  logic [NUM_REQ*8-1:0]          req_line_num,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [31:0]                   ldst_sdram_addr,
    output logic [RF_ADDR_W-1:0]          ldst_rf_addr,
    output logic [7:0]                    ldst_line_num,
    output logic                          load_start,
    output logic                          store_start,
    input  logic                          ldst_done,
    output logic                          busy,
    output logic [OWNER_W-1:0]            owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic                   store_q, store_d;
    logic [31:0]            sdram_addr_q, sdram_addr_d;
    logic [RF_ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [7:0]             remaining_q, remaining_d;
    logic [7:0]             chunk_q, chunk_d;
    logic [31:0]            ldst_sdram_addr_q, ldst_sdram_addr_d;
    logic [RF_ADDR_W-1:0]   ldst_rf_addr_q, ldst_rf_addr_d;
    logic [7:0]             ldst_line_num_q, ldst_line_num_d;
    logic                   load_start_q, load_start_d;
    logic                   store_start_q, store_start_d;
    logic [NUM_REQ-1:0]     req_done_q, req_done_d;

    logic [31:0]            addr_arr [NUM_REQ];
    logic [RF_ADDR_W-1:0]   rf_arr   [NUM_REQ];
    logic [7:0]             len_arr  [NUM_REQ];
    logic [OWNER_W:0]       rot_sum  [NUM_REQ];
    logic [OWNER_W-1:0]     rot_idx  [NUM_REQ];

    logic                   grant_any;
    logic [OWNER_W-1:0]     grant_idx;
    logic                   done_fire;
    logic [OWNER_W-1:0]     done_idx;

    logic                   launch;
    logic                   launch_store;
    logic [31:0]            launch_addr;
    logic [RF_ADDR_W-1:0]   launch_rf;
    logic [7:0]             launch_len;
    logic [31:0]            next_addr;
    logic [RF_ADDR_W-1:0]   next_rf;
    logic [7:0]             next_rem;

    function automatic logic [7:0] min_chunk(input logic [7:0] n);
        return (n > 8'(MAX_CHUNK)) ? 8'(MAX_CHUNK) : n;
    endfunction

    // Per-requester payload unpacking plus the rotated search order starting at rr_ptr.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign addr_arr[gi] = req_sdram_addr[gi*32 +: 32];
        assign rf_arr[gi]   = req_rf_addr[gi*RF_ADDR_W +: RF_ADDR_W];
        assign len_arr[gi]  = req_line_num[gi*8 +: 8];
        assign rot_sum[gi]  = {1'b0, rr_ptr_q} + (OWNER_W+1)'(gi);
        assign rot_idx[gi]  = (rot_sum[gi] >= (OWNER_W+1)'(NUM_REQ))
                            ? OWNER_W'(rot_sum[gi] - (OWNER_W+1)'(NUM_REQ))
                            : OWNER_W'(rot_sum[gi]);
        assign req_ready[gi]  = (state_q == ST_IDLE) && grant_any && (grant_idx == OWNER_W'(gi));
        assign req_done_d[gi] = done_fire && (done_idx == OWNER_W'(gi));
    end

    // Walk the rotated order from the far end so the nearest valid requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rot_idx[k]]) begin
                grant_any = 1'b1;
                grant_idx = rot_idx[k];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        owner_d           = owner_q;
        store_d           = store_q;
        sdram_addr_d      = sdram_addr_q;
        rf_addr_d         = rf_addr_q;
        remaining_d       = remaining_q;
        chunk_d           = chunk_q;
        ldst_sdram_addr_d = ldst_sdram_addr_q;
        ldst_rf_addr_d    = ldst_rf_addr_q;
        ldst_line_num_d   = ldst_line_num_q;
        load_start_d      = 1'b0;
        store_start_d     = 1'b0;
        done_fire         = 1'b0;
        done_idx          = owner_q;
        launch            = 1'b0;
        launch_store      = store_q;
        launch_addr       = sdram_addr_q;
        launch_rf         = rf_addr_q;
        launch_len        = remaining_q;
        next_addr         = sdram_addr_q + 32'(chunk_q) * 32'(LINE_BYTES);
        next_rf           = rf_addr_q + RF_ADDR_W'(chunk_q);
        next_rem          = remaining_q - chunk_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    owner_d      = grant_idx;
                    store_d      = req_store[grant_idx];
                    sdram_addr_d = addr_arr[grant_idx];
                    rf_addr_d    = rf_arr[grant_idx];
                    remaining_d  = len_arr[grant_idx];
                    if (len_arr[grant_idx] != 8'd0) begin
                        state_d      = ST_ISSUE;
                        launch       = 1'b1;
                        launch_store = req_store[grant_idx];
                        launch_addr  = addr_arr[grant_idx];
                        launch_rf    = rf_arr[grant_idx];
                        launch_len   = len_arr[grant_idx];
                    end else begin
                        state_d   = ST_DONE;
                        done_fire = 1'b1;
                        done_idx  = grant_idx;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ldst_done) begin
                    sdram_addr_d = next_addr;
                    rf_addr_d    = next_rf;
                    remaining_d  = next_rem;
                    if (next_rem != 8'd0) begin
                        state_d     = ST_ISSUE;
                        launch      = 1'b1;
                        launch_addr = next_addr;
                        launch_rf   = next_rf;
                        launch_len  = next_rem;
                    end else begin
                        state_d   = ST_DONE;
                        done_fire = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                rr_ptr_d = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Engine registers are loaded on the edge that enters ISSUE, so the start
        // pulse and its address/count appear together during the ISSUE cycle.
        if (launch) begin
            chunk_d           = min_chunk(launch_len);
            ldst_sdram_addr_d = launch_addr;
            ldst_rf_addr_d    = launch_rf;
            ldst_line_num_d   = min_chunk(launch_len);
            store_start_d     = launch_store;
            load_start_d      = !launch_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            rr_ptr_q          <= '0;
            owner_q           <= '0;
            store_q           <= 1'b0;
            sdram_addr_q      <= '0;
            rf_addr_q         <= '0;
            remaining_q       <= '0;
            chunk_q           <= '0;
            ldst_sdram_addr_q <= '0;
            ldst_rf_addr_q    <= '0;
            ldst_line_num_q   <= '0;
            load_start_q      <= 1'b0;
            store_start_q     <= 1'b0;
            req_done_q        <= '0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            owner_q           <= owner_d;
            store_q           <= store_d;
            sdram_addr_q      <= sdram_addr_d;
            rf_addr_q         <= rf_addr_d;
            remaining_q       <= remaining_d;
            chunk_q           <= chunk_d;
            ldst_sdram_addr_q <= ldst_sdram_addr_d;
            ldst_rf_addr_q    <= ldst_rf_addr_d;
            ldst_line_num_q   <= ldst_line_num_d;
            load_start_q      <= load_start_d;
            store_start_q     <= store_start_d;
            req_done_q        <= req_done_d;
        end
    end

    assign ldst_sdram_addr = ldst_sdram_addr_q;
    assign ldst_rf_addr    = ldst_rf_addr_q;
    assign ldst_line_num   = ldst_line_num_q;
    assign load_start      = load_start_q;
    assign store_start     = store_start_q;
    assign req_done        = req_done_q;
    assign busy            = (state_q != ST_IDLE);
    assign owner           = owner_q;

endmodule

// File: tb/tb_rf_ldst_sched.sv
// Bench for rf_ldst_sched: vector table, hand-written corner sequences and random commands
// checked against a chunk-list model of the command splitting and round-robin order.
module tb_rf_ldst_sched;

    localparam int NR = 2;
    localparam int AW = 9;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      req_store = '0;
    logic [NR*32-1:0]   req_sdram_addr = '0;
    logic [NR*AW-1:0]   req_rf_addr = '0;
    logic [NR*8-1:0]    req_line_num = '0;
    logic [NR-1:0]      req_done;
    logic [31:0]        ldst_sdram_addr;
    logic [AW-1:0]      ldst_rf_addr;
    logic [7:0]         ldst_line_num;
    logic               load_start;
    logic               store_start;
    logic               ldst_done = 1'b0;
    logic               busy;
    logic [0:0]         owner;

    always #5 clk = ~clk;

    rf_ldst_sched #(
        .NUM_REQ(NR), .RF_ADDR_W(AW), .LINE_BYTES(176), .MAX_CHUNK(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_sdram_addr(req_sdram_addr), .req_rf_addr(req_rf_addr),
        .req_line_num(req_line_num), .req_done(req_done),
        .ldst_sdram_addr(ldst_sdram_addr), .ldst_rf_addr(ldst_rf_addr),
        .ldst_line_num(ldst_line_num), .load_start(load_start),
        .store_start(store_start), .ldst_done(ldst_done),
        .busy(busy), .owner(owner)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [8:0]  r;
        logic [7:0]  n;
    } chunk_t;

    typedef struct {
        logic [1:0]  vmask;
        logic        st;
        logic [31:0] addr;
        logic [8:0]  rf;
        logic [7:0]  len;
        int          exp_g;
        int          exp_n;
        int          exp_last;
    } vec_t;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          m_rr   = 0;
    logic        pl_store [NR];
    logic [31:0] pl_addr  [NR];
    logic [8:0]  pl_rf    [NR];
    logic [7:0]  pl_len   [NR];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic drive_payload();
        req_store      = {pl_store[1], pl_store[0]};
        req_sdram_addr = {pl_addr[1], pl_addr[0]};
        req_rf_addr    = {pl_rf[1], pl_rf[0]};
        req_line_num   = {pl_len[1], pl_len[0]};
    endtask

    // Issues one arbitration round and plays the engine until req_done; returns at the
    // negedge of the req_done cycle. The expected chunk list is built from line arithmetic.
    task automatic do_cmd(input logic [1:0] vmask, input int lat_max, input bit hold,
                          output int g_seen, output int n_seen, output int last_len);
        chunk_t      exp_q[$];
        chunk_t      ch;
        int          g;
        int          rem;
        int          rfv;
        int          c;
        int          lat;
        logic [31:0] a;
        logic [1:0]  onehot;
        g = -1;
        for (int k = NR - 1; k >= 0; k--)
            if (vmask[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        onehot = 2'b01 << g;
        rem = int'(pl_len[g]);
        a   = pl_addr[g];
        rfv = int'(pl_rf[g]);
        while (rem > 0) begin
            c = (rem > 16) ? 16 : rem;
            ch.a = a; ch.r = 9'(rfv); ch.n = 8'(c);
            exp_q.push_back(ch);
            a   = a + 32'(c * 176);
            rfv = (rfv + c) % 512;
            rem = rem - c;
        end

        @(negedge clk);
        drive_payload();
        req_valid = vmask;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, onehot);
        g_seen   = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : -1;
        n_seen   = 0;
        last_len = 0;
        @(negedge clk);
        if (!hold) req_valid = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (load_start || store_start) begin
                n_seen++;
                last_len = int'(ldst_line_num);
            end
            chk("start", {store_start, load_start}, pl_store[g] ? 2'b10 : 2'b01);
            chk("ldst_addr", ldst_sdram_addr, exp_q[i].a);
            chk("ldst_rf", ldst_rf_addr, exp_q[i].r);
            chk("ldst_len", ldst_line_num, exp_q[i].n);
            chk("owner", owner, g);
            chk("no_early_done", req_done, 0);
            lat = $urandom_range(1, lat_max);
            repeat (lat) begin
                @(negedge clk);
                chk("wait_quiet", {store_start, load_start, req_done, req_ready}, 0);
                chk("wait_hold", ldst_line_num, exp_q[i].n);
            end
            ldst_done = 1'b1;
            @(negedge clk);
            ldst_done = 1'b0;
        end
        chk("req_done", req_done, onehot);
        chk("done_nostart", {store_start, load_start}, 0);
        m_rr = (g + 1) % NR;
        $display("cmd req=%0d store=%0d addr=%08h rf=%0d len=%0d chunks=%0d",
                 g, pl_store[g], pl_addr[g], pl_rf[g], pl_len[g], n_seen);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   gs, ns, ll;

        vecs[0] = '{2'b01, 1'b0, 32'h0000_1000, 9'd5,   8'd3,   0, 1,  3};
        vecs[1] = '{2'b10, 1'b1, 32'h0000_0000, 9'd500, 8'd40,  1, 3,  8};
        vecs[2] = '{2'b01, 1'b0, 32'h0000_0020, 9'd7,   8'd0,   0, 0,  0};
        vecs[3] = '{2'b11, 1'b1, 32'hFFFF_FF00, 9'd510, 8'd16,  1, 1, 16};
        vecs[4] = '{2'b11, 1'b0, 32'h0000_0100, 9'd3,   8'd17,  0, 2,  1};
        vecs[5] = '{2'b01, 1'b0, 32'hFFFF_FFF0, 9'd505, 8'd33,  0, 3,  1};
        vecs[6] = '{2'b11, 1'b1, 32'h0000_0000, 9'd0,   8'd255, 1, 16, 15};
        vecs[7] = '{2'b10, 1'b1, 32'h0000_0040, 9'd9,   8'd32,  1, 2, 16};

        // Reset state
        @(negedge clk);
        chk("rst_outs", {req_done, load_start, store_start, busy, owner, req_ready}, 0);
        chk("rst_ldst", {ldst_sdram_addr, ldst_rf_addr, ldst_line_num}, 0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < NR; r++) begin
                pl_store[r] = vecs[i].st;
                pl_addr[r]  = vecs[i].addr;
                pl_rf[r]    = vecs[i].rf;
                pl_len[r]   = vecs[i].len;
            end
            do_cmd(vecs[i].vmask, 3, 1'b0, gs, ns, ll);
            chk("vec_grant", gs, vecs[i].exp_g);
            chk("vec_chunks", ns, vecs[i].exp_n);
            chk("vec_last", ll, vecs[i].exp_last);
        end

        // Both requesters held valid: grants must alternate 0,1,0,1
        for (int r = 0; r < NR; r++) begin
            pl_store[r] = 1'b0;
            pl_addr[r]  = 32'h100 * (r + 1);
            pl_rf[r]    = 9'(r + 1);
            pl_len[r]   = 8'd1;
        end
        for (int k = 0; k < 4; k++) begin
            do_cmd(2'b11, 2, 1'b1, gs, ns, ll);
            chk("rr_order", gs, k % 2);
        end
        req_valid = '0;

        // Spurious ldst_done in IDLE
        @(negedge clk);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        chk("spur_idle", {busy, store_start, load_start, req_done}, 0);

        // Spurious ldst_done in ISSUE must not advance the 2-line command
        @(negedge clk);
        pl_store[0] = 1'b0; pl_addr[0] = 32'h200; pl_rf[0] = 9'd2; pl_len[0] = 8'd2;
        drive_payload();
        req_valid = 2'b01;
        #1;
        chk("spur_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        chk("spur_issue_start", {store_start, load_start}, 2'b01);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        chk("spur_wait1", {busy, store_start, load_start, req_done}, 5'b10000);
        @(negedge clk);
        chk("spur_wait2", {busy, store_start, load_start, req_done}, 5'b10000);
        ldst_done = 1'b1;
        @(negedge clk);
        ldst_done = 1'b0;
        chk("spur_done", req_done, 2'b01);
        m_rr = 1;

        // Reset during WAIT of a 3-chunk store from requester 1
        @(negedge clk);
        pl_store[1] = 1'b1; pl_addr[1] = 32'h500; pl_rf[1] = 9'd100; pl_len[1] = 8'd40;
        drive_payload();
        req_valid = 2'b10;
        #1;
        chk("rst_test_ready", req_ready, 2'b10);
        @(negedge clk);
        req_valid = '0;
        chk("rst_test_start", {store_start, load_start}, 2'b10);
        @(negedge clk);
        chk("rst_test_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {req_done, load_start, store_start, busy, owner}, 0);
        chk("midrst_ldst", {ldst_sdram_addr, ldst_rf_addr, ldst_line_num}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_quiet", {req_done, busy}, 0);
        end
        pl_len[0] = 8'd1; pl_len[1] = 8'd1;
        do_cmd(2'b11, 2, 1'b0, gs, ns, ll);
        chk("post_rst_grant", gs, 0);

        // Random commands
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < NR; r++) begin
                pl_store[r] = 1'($urandom_range(0, 1));
                pl_addr[r]  = $urandom;
                pl_rf[r]    = 9'($urandom_range(0, 511));
                pl_len[r]   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            end
            do_cmd(2'($urandom_range(1, 3)), 4, 1'b0, gs, ns, ll);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
